frodo_mul_stream: RTL and testbench
===================================

# frodo_mul_stream

Sequenced, parametrised successor to the FrodoKEM matrix-multiply datapath. It runs a complete multiply-accumulate job of runtime length under valid/ready handshakes:
- mul1 (`isMatrixMul1=1`): produces `outVec = accVec ± Σ_k sMat_k·a_k`.
- mul2 (`isMatrixMul1=0`): produces one `outMat_k = accMat_k ± sCol·a_k` per beat.

It sits between the A/B matrix generator (source of `a` beats) and the transcript/ciphertext buffers, and replaces external per-cycle `setStorage`/`doOp` sequencing with an internal FSM and modulo-2^LOGQ reduction.

## Interface
- A, 4, lanes of `a` per beat (columns per beat).
- S, 8, rows held in the accumulator / `sCol`.
- LOGQ, 16, log2 of modulus q; legal 15 or 16.
- LENW, 12, width of the job-length field.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; accepted only in IDLE.
- isMatrixMul1  in  1  mode, sampled at `start`.
- isPos  in  1  sign, sampled at `start`; 1 = add, 0 = subtract.
- len  in  LENW  beats in the job, sampled at `start`.
- accVec  in  16·S  mul1 initial accumulator, sampled at `start`.
- sCol  in  4·S  mul2 secret column, sampled at `start`.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat ready.
- a  in  16·A  `a` lanes, lane i at `[16i+:16]`.
- sMat  in  4·A·S  mul1 secrets; element (j,i) at `[(jA+i)·4+:4]`.
- accMat  in  16·A·S  mul2 addends, same indexing at 16 b.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- outVec  out  16·S  mul1 result.
- outMat  out  16·A·S  mul2 per-beat result.
- done  out  1  one-cycle pulse when the job completes.

## Operation
- Secret encoding: 4-bit sign-magnitude. Bit 3 is the sign; bits 2:0 are the magnitude, legal 0..6. Magnitude 7 is reserved and must produce 3·a (identical to the existing multiplier). `isPos=0` XORs bit 3.
- Arithmetic: all arithmetic is mod 2^16 internally. Every stored or output 16-bit word is masked to LOGQ bits, with the upper bits zero.
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - `start=1` samples the mode, `isPos`, `len`, `accVec`/`sCol` and sets `cnt=len`.
  - If `len≠0`, go to RUN.
  - If `len=0`: mul1 goes to OUT with `outVec=accVec` (masked); mul2 pulses `done` and stays in IDLE.
- RUN, mul1:
  - `in_ready=1`.
  - Each accepted beat: `acc_j ← acc_j + Σ_i s(j,i)·a_i`, then `cnt−1`.
  - When the beat with `cnt=1` is accepted, go to OUT.
- OUT (mul1 only):
  - `out_valid=1`, `outVec=acc`, `in_ready=0`.
  - `out_valid` holds until `out_ready`. On the handshake: `done=1`, go to IDLE.
- RUN, mul2:
  - `in_ready = !out_valid || out_ready`, forming a one-deep output register.
  - An accepted beat registers `outMat_(j,i) = accMat_(j,i) + s_j·a_i` and sets `out_valid`, then `cnt−1`.
  - If an output is consumed with no new beat, `out_valid` clears.
  - After the last beat's output is consumed: `done=1`, go to IDLE.
- `start` outside IDLE is ignored.
- `in_valid` outside RUN is ignored.
- Output hold: `outVec`/`outMat` are stable while `out_valid=1` and `out_ready=0`. Otherwise their value is don't-care, except that after reset they are 0.

## Timing
- Reset values: `busy=0`, `in_ready=0`, `out_valid=0`, `done=0`, `outVec=0`, `outMat=0`. State returns to IDLE. Accumulator, `cnt` and stored `sCol` are cleared.
- Reset mid-job aborts the job with no `done`. A `start` coincident with `rst` is ignored.
- Latency from `start` to `in_ready`: 1 cycle.
- mul1:
  - Throughput is 1 beat/cycle.
  - `out_valid` rises in the cycle after the last beat handshake, so a job of `len=n` with continuous input takes `n+1` cycles to `out_valid`.
  - `done` is asserted in the cycle of the output handshake, and `busy` falls in the next cycle.
- mul2:
  - Latency is 1 cycle from beat handshake to `out_valid`.
  - Full throughput is maintained when `out_ready=1`.
  - Simultaneous consume and accept updates the register without a bubble.
- Earliest restart: `start` is accepted in the first cycle back in IDLE.

## Test plan
- mul1, A=4, S=8, `len=1`, `isPos=1`, `accVec` all 0x0010, `a` = {1,2,3,4}, all s = 0x1 → `outVec` all 0x001A, with `out_valid` 2 cycles after `start`.
- mul1 with `isPos=0`, `len=3`, `accVec=0`, `a` lanes 0x0001, s = 0x6 → each `outVec` word = −72 mod 2^16 = 0xFFB8. Repeat with LOGQ=15 → 0x7FB8.
- mul2, `len=4`, `sCol` row j = 0xA (−2), `accMat=0x0100`, `a_i=0x0003`, with `out_ready` low for 3 cycles after the first output → every `outMat` word is 0x00FA. `outMat` holds during the stall, `in_ready=0` while stalled, exactly 4 outputs are produced, then `done`.
- `len=0`: mul1 gives `out_valid` next cycle with `outVec=accVec`; mul2 pulses `done` with no `out_valid`.
- `rst` asserted mid-RUN with 2 beats left → next cycle all outputs are 0 and IDLE; a new job then yields the correct result, unaffected by the old accumulator.
- `start` pulsed while busy, and `in_valid` asserted in IDLE → no effect on the result or the beat count.
- Reserved magnitude: s = 0x7 with `a=5` → product 15.

Source files
------------

// File: rtl/frodo_mul_stream.sv
// Streaming FrodoKEM matrix multiply-accumulate: mul1 folds a whole job into one
// accumulator vector, mul2 emits one accumulated matrix per input beat.
module frodo_mul_stream #(
  parameter int A    = 4,
  parameter int S    = 8,
  parameter int LOGQ = 16,
  parameter int LENW = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  isMatrixMul1,
  input  logic                  isPos,
  input  logic [LENW-1:0]       len,
  input  logic [16*S-1:0]       accVec,
  input  logic [4*S-1:0]        sCol,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*A-1:0]       a,
  input  logic [4*A*S-1:0]      sMat,
  input  logic [16*A*S-1:0]     accMat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*S-1:0]       outVec,
  output logic [16*A*S-1:0]     outMat,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  localparam logic [15:0] MASK = 16'((32'd1 << LOGQ) - 32'd1);

  state_t                stateReg;
  logic [LENW-1:0]       cntReg;
  logic                  mul1Reg;
  logic                  negReg;
  logic [4*S-1:0]        sColReg;
  logic [15:0]           accReg  [S];
  logic [15:0]           accNext [S];
  logic                  outValidReg;
  logic [16*A*S-1:0]     outMatReg;
  logic [16*A*S-1:0]     prodMat;
  logic                  inFire;

  // Sign-magnitude secret times a word, mod 2^16; magnitude 7 behaves as 3.
  function automatic logic [15:0] secretMul(input logic [3:0] s, input logic [15:0] x,
                                            input logic flip);
    logic [15:0] m;
    case (s[2:0])
      3'd0:    m = '0;
      3'd1:    m = x;
      3'd2:    m = x << 1;
      3'd3:    m = x + (x << 1);
      3'd4:    m = x << 2;
      3'd5:    m = x + (x << 2);
      3'd6:    m = (x << 1) + (x << 2);
      default: m = x + (x << 1);
    endcase
    return (s[3] ^ flip) ? (~m + 16'd1) : m;
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < S; gi++) begin : g_row
      logic [15:0] rowSum;
      always_comb begin
        rowSum = accReg[gi];
        for (int i = 0; i < A; i++)
          rowSum = rowSum + secretMul(sMat[(gi*A+i)*4 +: 4], a[16*i +: 16], negReg);
      end
      assign accNext[gi] = rowSum & MASK;
      assign outVec[16*gi +: 16] = accReg[gi];

      for (gj = 0; gj < A; gj++) begin : g_col
        assign prodMat[(gi*A+gj)*16 +: 16] =
          (accMat[(gi*A+gj)*16 +: 16] + secretMul(sColReg[4*gi +: 4], a[16*gj +: 16], negReg)) & MASK;
      end
    end
  endgenerate

  // mul2 keeps a one-deep output register; it may refill in the cycle it drains.
  assign in_ready  = (stateReg == RUN) &&
                     (mul1Reg || ((cntReg != '0) && (!outValidReg || out_ready)));
  assign inFire    = in_valid && in_ready;
  assign busy      = (stateReg != IDLE);
  assign out_valid = (stateReg == OUT) || outValidReg;
  assign outMat    = outMatReg;
  assign done      = !rst &&
                     (((stateReg == OUT) && out_ready) ||
                      ((stateReg == RUN) && !mul1Reg && (cntReg == '0) && outValidReg && out_ready) ||
                      ((stateReg == IDLE) && start && !isMatrixMul1 && (len == '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      mul1Reg     <= 1'b0;
      negReg      <= 1'b0;
      sColReg     <= '0;
      outValidReg <= 1'b0;
      outMatReg   <= '0;
      for (int j = 0; j < S; j++) accReg[j] <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            mul1Reg <= isMatrixMul1;
            negReg  <= !isPos;
            cntReg  <= len;
            sColReg <= sCol;
            for (int j = 0; j < S; j++) accReg[j] <= accVec[16*j +: 16] & MASK;
            if (len != '0)        stateReg <= RUN;
            else if (isMatrixMul1) stateReg <= OUT;
          end
        end
        RUN: begin
          if (mul1Reg) begin
            if (inFire) begin
              accReg <= accNext;
              cntReg <= cntReg - LENW'(1);
              if (cntReg == LENW'(1)) stateReg <= OUT;
            end
          end else begin
            if (inFire) begin
              outMatReg   <= prodMat;
              outValidReg <= 1'b1;
              cntReg      <= cntReg - LENW'(1);
            end else if (out_ready) begin
              outValidReg <= 1'b0;
            end
            if ((cntReg == '0) && outValidReg && out_ready) stateReg <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frodo_mul_stream.sv
// Randomised and directed bench for frodo_mul_stream, comparing a 16-bit and a
// 15-bit modulus instance against a plain-arithmetic reference model.
module tb_frodo_mul_stream;
  localparam int A = 4;
  localparam int S = 8;
  localparam int LENW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, isMatrixMul1, isPos, in_valid, out_ready;
  logic [LENW-1:0]      len;
  logic [16*S-1:0]      accVec;
  logic [4*S-1:0]       sCol;
  logic [16*A-1:0]      a;
  logic [4*A*S-1:0]     sMat;
  logic [16*A*S-1:0]    accMat;

  logic busy16, inReady16, outValid16, done16;
  logic busy15, inReady15, outValid15, done15;
  logic [16*S-1:0]   outVec16, outVec15;
  logic [16*A*S-1:0] outMat16, outMat15;

  frodo_mul_stream #(.A(A), .S(S), .LOGQ(16), .LENW(LENW)) dut16 (
    .clk(clk), .rst(rst), .start(start), .isMatrixMul1(isMatrixMul1), .isPos(isPos),
    .len(len), .accVec(accVec), .sCol(sCol), .busy(busy16), .in_valid(in_valid),
    .in_ready(inReady16), .a(a), .sMat(sMat), .accMat(accMat), .out_valid(outValid16),
    .out_ready(out_ready), .outVec(outVec16), .outMat(outMat16), .done(done16));

  frodo_mul_stream #(.A(A), .S(S), .LOGQ(15), .LENW(LENW)) dut15 (
    .clk(clk), .rst(rst), .start(start), .isMatrixMul1(isMatrixMul1), .isPos(isPos),
    .len(len), .accVec(accVec), .sCol(sCol), .busy(busy15), .in_valid(in_valid),
    .in_ready(inReady15), .a(a), .sMat(sMat), .accMat(accMat), .out_valid(outValid15),
    .out_ready(out_ready), .outVec(outVec15), .outMat(outMat15), .done(done15));

  int checks = 0;
  int passes = 0;
  logic [16*S-1:0]   lastVec16, lastVec15;
  logic [16*A*S-1:0] lastMat16, lastMat15;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed value of a secret times a lane, as an unbounded integer.
  function automatic int term(input logic [3:0] s, input logic [15:0] x, input logic pos);
    int mag;
    mag = (s[2:0] == 3'd7) ? 3 : int'(s[2:0]);
    return (s[3] ^ !pos) ? -(mag * int'(x)) : mag * int'(x);
  endfunction

  function automatic logic [511:0] mask15(input logic [511:0] v);
    logic [511:0] r;
    for (int w = 0; w < 32; w++) r[16*w +: 16] = v[16*w +: 16] & 16'h7FFF;
    return r;
  endfunction

  task automatic randomizeBeat();
    for (int w = 0; w < 2; w++)  a[32*w +: 32] = $urandom;
    for (int w = 0; w < 4; w++)  sMat[32*w +: 32] = $urandom;
    for (int w = 0; w < 16; w++) accMat[32*w +: 32] = $urandom;
  endtask

  task automatic runMul1(input int n, input logic pos, input logic [16*S-1:0] av, input bit fixed,
                         input logic [16*A-1:0] fa, input logic [4*A*S-1:0] fs);
    int expW[S];
    int k, guard, stall;
    logic [16*S-1:0] ev;
    for (int j = 0; j < S; j++) expW[j] = int'(av[16*j +: 16]);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b0; randomizeBeat();
    #1; check("idle_in_ready", inReady16, 1'b0);
    tick();
    in_valid = 1'b0;
    start = 1'b1; isMatrixMul1 = 1'b1; isPos = pos; len = LENW'(n); accVec = av;
    tick();
    start = 1'b0; isPos = 1'($urandom); len = LENW'($urandom);
    #1; check("m1_busy", busy16, 1'b1);
    k = 0; guard = 0;
    while (k < n && guard < 1000) begin
      in_valid = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 4) == 0);
      isMatrixMul1 = 1'($urandom);
      randomizeBeat();
      if (fixed) begin a = fa; sMat = fs; end
      #1;
      check("m1_in_ready", inReady16, 1'b1);
      check("m1_out_valid_run", outValid16, 1'b0);
      if (in_valid) begin
        for (int j = 0; j < S; j++)
          for (int i = 0; i < A; i++)
            expW[j] += term(sMat[(j*A+i)*4 +: 4], a[16*i +: 16], pos);
        k++;
      end
      tick();
      guard++;
    end
    check("m1_beat_budget", k, n);
    for (int j = 0; j < S; j++) ev[16*j +: 16] = 16'(expW[j]);
    start = 1'b0; in_valid = 1'b1; randomizeBeat();
    stall = fixed ? 0 : $urandom_range(0, 3);
    repeat (stall) begin
      out_ready = 1'b0;
      #1;
      check("m1_out_valid_hold", outValid16, 1'b1);
      check("m1_vec_hold", outVec16, ev);
      check("m1_done_early", done16, 1'b0);
      check("m1_in_ready_out", inReady16, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("m1_out_valid", outValid16, 1'b1);
    check("m1_vec16", outVec16, ev);
    check("m1_vec15", outVec15, mask15(ev));
    check("m1_done", done16, 1'b1);
    check("m1_done15", done15, 1'b1);
    lastVec16 = outVec16; lastVec15 = outVec15;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("m1_busy_end", busy16, 1'b0);
    check("m1_done_end", done16, 1'b0);
  endtask

  task automatic runMul2(input int n, input logic pos, input logic [4*S-1:0] sc, input bit fixed,
                         input logic [16*A-1:0] fa, input logic [16*A*S-1:0] fam, input bit stall3);
    logic [16*A*S-1:0] q[$];
    logic [16*A*S-1:0] em;
    int accepted, consumed, guard, stallLeft;
    bit doneSeen, expReady, expDone;
    accepted = 0; consumed = 0; guard = 0; doneSeen = 0; stallLeft = stall3 ? 3 : 0;
    start = 1'b1; isMatrixMul1 = 1'b0; isPos = pos; len = LENW'(n); sCol = sc;
    in_valid = 1'b0; out_ready = 1'b0;
    #1; check("m2_start_done", done16, (n == 0));
    tick();
    start = 1'b0; sCol = $urandom; isPos = 1'($urandom);
    if (n == 0) begin
      #1;
      check("m2_len0_busy", busy16, 1'b0);
      check("m2_len0_valid", outValid16, 1'b0);
      return;
    end
    while (!doneSeen && guard < 2000) begin
      randomizeBeat();
      if (fixed) begin a = fa; accMat = fam; end
      in_valid = fixed ? (accepted < n) : ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 4) == 0);
      isMatrixMul1 = 1'($urandom);
      if (q.size() != 0 && stallLeft > 0) begin out_ready = 1'b0; stallLeft--; end
      else out_ready = fixed ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      expReady = (accepted < n) && (q.size() == 0 || out_ready);
      expDone  = (accepted == n) && (q.size() != 0) && out_ready;
      check("m2_in_ready", inReady16, expReady);
      check("m2_out_valid", outValid16, q.size() != 0);
      check("m2_done", done16, expDone);
      if (q.size() != 0) begin
        check("m2_mat16", outMat16, q[0]);
        check("m2_mat15", outMat15, mask15(q[0]));
        if (out_ready) begin
          lastMat16 = outMat16; lastMat15 = outMat15;
          void'(q.pop_front());
          consumed++;
        end
      end
      if (in_valid && expReady) begin
        for (int j = 0; j < S; j++)
          for (int i = 0; i < A; i++)
            em[(j*A+i)*16 +: 16] = 16'(int'(accMat[(j*A+i)*16 +: 16]) +
                                      term(sc[4*j +: 4], a[16*i +: 16], pos));
        q.push_back(em);
        accepted++;
      end
      if (expDone) doneSeen = 1'b1;
      tick();
      guard++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("m2_done_seen", doneSeen, 1'b1);
    check("m2_out_count", consumed, n);
    check("m2_busy_end", busy16, 1'b0);
  endtask

  initial begin
    logic [16*S-1:0] rv;
    rst = 1'b1; start = 1'b0; isMatrixMul1 = 1'b0; isPos = 1'b1; len = '0;
    accVec = '0; sCol = '0; in_valid = 1'b0; out_ready = 1'b0; a = '0; sMat = '0; accMat = '0;
    tick(); tick();
    check("rst_busy", busy16, 1'b0);
    check("rst_in_ready", inReady16, 1'b0);
    check("rst_out_valid", outValid16, 1'b0);
    check("rst_done", done16, 1'b0);
    check("rst_vec", outVec16, '0);
    check("rst_mat", outMat16, '0);
    rst = 1'b0;

    runMul1(1, 1'b1, {S{16'h0010}}, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, {(A*S){4'h1}});
    check("plan_m1_basic", lastVec16, {S{16'h001A}});
    runMul1(3, 1'b0, '0, 1'b1, {A{16'h0001}}, {(A*S){4'h6}});
    check("plan_m1_neg16", lastVec16, {S{16'hFFB8}});
    check("plan_m1_neg15", lastVec15, {S{16'h7FB8}});
    runMul2(4, 1'b1, {S{4'hA}}, 1'b1, {A{16'h0003}}, {(A*S){16'h0100}}, 1'b1);
    check("plan_m2_stall", lastMat16, {(A*S){16'h00FA}});
    runMul2(1, 1'b1, {S{4'h7}}, 1'b1, {A{16'd5}}, '0, 1'b0);
    check("plan_reserved", lastMat16, {(A*S){16'h000F}});

    for (int w = 0; w < 4; w++) rv[32*w +: 32] = $urandom;
    runMul1(0, 1'b1, rv, 1'b0, '0, '0);
    check("plan_m1_len0", lastVec16, rv);
    runMul2(0, 1'b0, 32'h1234_5678, 1'b0, '0, '0, 1'b0);

    // Abort a mul1 job with two beats outstanding, with a start riding on reset.
    start = 1'b1; isMatrixMul1 = 1'b1; isPos = 1'b1; len = LENW'(4);
    for (int w = 0; w < 4; w++) accVec[32*w +: 32] = $urandom;
    tick();
    start = 1'b0; in_valid = 1'b1; randomizeBeat();
    tick(); tick();
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("abort_busy", busy16, 1'b0);
    check("abort_in_ready", inReady16, 1'b0);
    check("abort_out_valid", outValid16, 1'b0);
    check("abort_done", done16, 1'b0);
    check("abort_vec", outVec16, '0);
    check("abort_mat", outMat16, '0);
    runMul1(1, 1'b1, {S{16'h0010}}, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, {(A*S){4'h1}});
    check("abort_rerun", lastVec16, {S{16'h001A}});

    repeat (15) begin
      for (int w = 0; w < 4; w++) rv[32*w +: 32] = $urandom;
      runMul1($urandom_range(1, 8), 1'($urandom), rv, 1'b0, '0, '0);
      runMul2($urandom_range(1, 8), 1'($urandom), $urandom, 1'b0, '0, '0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
